// File: rtl/aoi222_tester_pkg.sv
// Shared constants, FSM state encoding and golden function for the AOI222 exhaustive tester.
package aoi222_tester_pkg;

    localparam int VEC_W   = 6;
    localparam int NUM_VEC = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } tester_state_e;

    // vec = {A1,A2,B1,B2,C1,C2}
    function automatic logic aoi222_golden(input logic [VEC_W-1:0] vec);
        return ~((vec[5] & vec[4]) | (vec[3] & vec[2]) | (vec[1] & vec[0]));
    endfunction

endpackage

// File: rtl/aoi222_golden_model.sv
// Combinational golden ZN generator for the AOI222 cell; shared with other library benches.
module aoi222_golden_model
    import aoi222_tester_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             exp_zn
);

    assign exp_zn = aoi222_golden(vec);

endmodule

// File: rtl/aoi222_exhaustive_tester.sv
// Exhaustive 64-vector stimulus/response checker for the AOI222 cell.
// Optional: GF180MCU_AOI222_TESTER_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
//
// state  | meaning
// IDLE   | stimulus 0, waiting for START; results held
// RUN    | applying vec, counting settle time, sampling ZN
// FINISH | one cycle: drop BUSY, raise DONE, compute PASS
module aoi222_exhaustive_tester
    import aoi222_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 7
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    output logic             A1,
    output logic             A2,
    output logic             B1,
    output logic             B2,
    output logic             C1,
    output logic             C2,
    input  logic             ZN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FIRST_FAIL_VLD,
    output logic [5:0]       FIRST_FAIL_VEC
);

    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    tester_state_e     state;
    logic [VEC_W-1:0]  vec;
    logic [CNT_W-1:0]  settle_cnt;
    logic [ERR_W-1:0]  err_cnt;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              ff_vld;
    logic [VEC_W-1:0]  ff_vec;
    logic              exp_zn;
    logic              mismatch;
    logic              last_vec;
    logic              end_sweep;

    aoi222_golden_model u_golden (
        .vec    (vec),
        .exp_zn (exp_zn)
    );

    // 4-state identity: X or Z on ZN is a mismatch
    assign mismatch = (ZN !== exp_zn);
    assign last_vec = (vec == VEC_W'(NUM_VEC - 1));

`ifdef GF180MCU_AOI222_TESTER_STOP_ON_FAIL_EN
    assign end_sweep = last_vec || mismatch;
`else
    assign end_sweep = last_vec;
`endif

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            ff_vld     <= 1'b0;
            ff_vec     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        err_cnt    <= '0;
                        ff_vld     <= 1'b0;
                        ff_vec     <= '0;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        vec        <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        busy_q     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else begin
                        if (mismatch) begin
                            err_cnt <= err_cnt + ERR_W'(1);
                            if (!ff_vld) begin
                                ff_vld <= 1'b1;
                                ff_vec <= vec;
                            end
                        end
                        if (end_sweep) begin
                            state <= FINISH;
                        end else begin
                            vec        <= vec + 1'b1;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                FINISH: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (err_cnt == '0);
                    vec    <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {A1, A2, B1, B2, C1, C2} = vec;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign PASS           = pass_q;
    assign ERR_CNT        = err_cnt;
    assign FIRST_FAIL_VLD = ff_vld;
    assign FIRST_FAIL_VEC = ff_vec;

endmodule

// File: tb/tb_aoi222_exhaustive_tester.sv
// Scoreboard bench for aoi222_exhaustive_tester with a fault-injectable AOI222 cell model.
module tb_aoi222_exhaustive_tester;

    typedef struct {
        int done_at;
        int err;
        int vld;
        int vec;
        int pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rn;
    logic       start;
    logic       start0;
    logic       a1, a2, b1, b2, c1, c2;
    logic       zn;
    logic       busy, done, pass, ff_vld;
    logic [6:0] err_cnt;
    logic [5:0] ff_vec;

    logic       s0_a1, s0_a2, s0_b1, s0_b2, s0_c1, s0_c2;
    logic       s0_zn, s0_busy, s0_done, s0_pass, s0_ff_vld;
    logic [6:0] s0_err_cnt;
    logic [5:0] s0_ff_vec;

    int   mode;
    int   edge_n = 0;
    int   n_chk  = 0;
    int   n_err  = 0;
    logic done_prev = 1'b0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    aoi222_exhaustive_tester #(.SETTLE_CYCLES(1), .ERR_W(7)) dut (
        .CLK(clk), .RN(rn), .START(start),
        .A1(a1), .A2(a2), .B1(b1), .B2(b2), .C1(c1), .C2(c2),
        .ZN(zn), .BUSY(busy), .DONE(done), .PASS(pass),
        .ERR_CNT(err_cnt), .FIRST_FAIL_VLD(ff_vld), .FIRST_FAIL_VEC(ff_vec)
    );

    aoi222_exhaustive_tester #(.SETTLE_CYCLES(0), .ERR_W(7)) dut_s0 (
        .CLK(clk), .RN(rn), .START(start0),
        .A1(s0_a1), .A2(s0_a2), .B1(s0_b1), .B2(s0_b2), .C1(s0_c1), .C2(s0_c2),
        .ZN(s0_zn), .BUSY(s0_busy), .DONE(s0_done), .PASS(s0_pass),
        .ERR_CNT(s0_err_cnt), .FIRST_FAIL_VLD(s0_ff_vld), .FIRST_FAIL_VEC(s0_ff_vec)
    );

    // cell model: 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 missing A term, 4 X on vector 10
    always_comb begin
        zn = ~((a1 & a2) | (b1 & b2) | (c1 & c2));
        case (mode)
            1: zn = 1'b1;
            2: zn = 1'b0;
            3: zn = ~((b1 & b2) | (c1 & c2));
            4: if ({a1, a2, b1, b2, c1, c2} == 6'd10) zn = 1'bx;
            default: ;
        endcase
    end

    assign s0_zn = ~((s0_a1 & s0_a2) | (s0_b1 & s0_b2) | (s0_c1 & s0_c2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_time", edge_n, e.done_at);
                chk("err_cnt", 32'(err_cnt), e.err);
                chk("first_fail_vld", 32'(ff_vld), e.vld);
                chk("first_fail_vec", 32'(ff_vec), e.vec);
                chk("pass", 32'(pass), e.pass);
                chk("busy_at_done", 32'(busy), 0);
            end
        end
        done_prev <= done;
    end

    task automatic run_sweep(input int mode_i, input int err, input int vec, input int vld,
                             input int pass_e, input bit repulse, input bit with_s0);
        int k;
        exp_t e;
        mode = mode_i;
        @(negedge clk);
        start = 1'b1;
        if (with_s0) start0 = 1'b1;
        k = edge_n;
        e.done_at = k + 130; e.err = err; e.vld = vld; e.vec = vec; e.pass = pass_e;
        sb_q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        start0 = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        while (edge_n < k + 131) begin
            @(negedge clk);
            start = repulse && (edge_n == k + 5 || edge_n == k + 60);
            if (edge_n == k + 129) chk("busy_last", 32'(busy), 1);
            if (with_s0 && edge_n == k + 65) chk("s0_done_early", 32'(s0_done), 0);
            if (with_s0 && edge_n == k + 66) begin
                chk("s0_done", 32'(s0_done), 1);
                chk("s0_pass", 32'(s0_pass), 1);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_sticky", 32'(done), 1);
        chk("stim_idle", 32'({a1, a2, b1, b2, c1, c2}), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
        chk({tag, "_ff_vld"}, 32'(ff_vld), 0);
        chk({tag, "_ff_vec"}, 32'(ff_vec), 0);
        chk({tag, "_stim"}, 32'({a1, a2, b1, b2, c1, c2}), 0);
    endtask

    initial begin
        int k;
        rn = 1'b0; start = 1'b0; start0 = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rn = 1'b1;
        @(negedge clk);

        run_sweep(0, 0, 0, 0, 1, 1'b0, 1'b1);
        run_sweep(1, 37, 3, 1, 0, 1'b0, 1'b0);
        run_sweep(2, 27, 0, 1, 0, 1'b0, 1'b0);
        run_sweep(3, 9, 48, 1, 0, 1'b0, 1'b0);
        run_sweep(4, 1, 10, 1, 0, 1'b0, 1'b0);
        run_sweep(0, 0, 0, 0, 1, 1'b1, 1'b0);

        // mid-sweep reset with errors already accumulated
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        k = edge_n;
        @(negedge clk);
        start = 1'b0;
        while (edge_n < k + 50) @(negedge clk);
        @(posedge clk);
        #1;
        chk("busy_before_reset", 32'(busy), 1);
        chk("err_before_reset_nonzero", 32'(err_cnt != 0), 1);
        rn = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rn = 1'b1;
        run_sweep(0, 0, 0, 0, 1, 1'b0, 1'b0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running required finished");
        $fatal(1);
    end

endmodule
